// File: rtl/csd_pkg.sv
// Shared state encoding and default widths for the csd_chain_seq job sequencer.
package csd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } seq_state_e;

    localparam int unsigned CSD_NUM_DGS        = 4;
    localparam int unsigned CSD_DATA_WIDTH     = 8;
    localparam int unsigned CSD_ACCUM_WIDTH    = 48;
    localparam int unsigned CSD_LEN_WIDTH      = 16;
    localparam int unsigned CSD_TIMEOUT_CYCLES = 1024;

    function automatic logic state_is_busy(input seq_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/csd_chain_seq_if.sv
// Bundle of job, element, chain and result signals between the tile and the sequencer.
interface csd_chain_seq_if #(
    parameter int unsigned NUM_DGS     = csd_pkg::CSD_NUM_DGS,
    parameter int unsigned DATA_WIDTH  = csd_pkg::CSD_DATA_WIDTH,
    parameter int unsigned ACCUM_WIDTH = csd_pkg::CSD_ACCUM_WIDTH,
    parameter int unsigned LEN_WIDTH   = csd_pkg::CSD_LEN_WIDTH
);

    logic                   job_valid;
    logic                   job_ready;
    logic [LEN_WIDTH-1:0]   job_len;
    logic [NUM_DGS-1:0]     job_mask;
    logic                   job_mode;

    logic                   elem_valid;
    logic                   elem_ready;
    logic [DATA_WIDTH-1:0]  elem_act;
    logic [DATA_WIDTH-1:0]  elem_wgt;

    logic [DATA_WIDTH-1:0]  vpu_act;
    logic [DATA_WIDTH-1:0]  vpu_wgt;
    logic [NUM_DGS-1:0]     vpu_sparse_index;
    logic                   vpu_mode;
    logic                   vpu_start;
    logic                   vpu_done;
    logic [ACCUM_WIDTH-1:0] vpu_result;

    logic                   res_valid;
    logic                   res_ready;
    logic [ACCUM_WIDTH-1:0] res_data;
    logic                   res_err;
    logic                   busy;

    // Environment side: command queue, element source, chain and result sink.
    modport master (
        output job_valid, job_len, job_mask, job_mode,
        output elem_valid, elem_act, elem_wgt,
        output vpu_done, vpu_result,
        output res_ready,
        input  job_ready, elem_ready,
        input  vpu_act, vpu_wgt, vpu_sparse_index, vpu_mode, vpu_start,
        input  res_valid, res_data, res_err, busy
    );

    modport slave (
        input  job_valid, job_len, job_mask, job_mode,
        input  elem_valid, elem_act, elem_wgt,
        input  vpu_done, vpu_result,
        input  res_ready,
        output job_ready, elem_ready,
        output vpu_act, vpu_wgt, vpu_sparse_index, vpu_mode, vpu_start,
        output res_valid, res_data, res_err, busy
    );

endinterface

// File: rtl/csd_seq_elem_cnt.sv
// Loadable down-counter of remaining element pairs, with zero and last-element flags.
module csd_seq_elem_cnt #(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 is_zero,
    output logic                 is_last
);

    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero = (cnt_q == '0);
    assign is_last = (cnt_q == LEN_WIDTH'(1));

endmodule

// File: rtl/csd_chain_seq.sv
// Job sequencer for one Configurable Sparse DSP Chain run per descriptor.
// Optional WAIT watchdog compiled in with `define CSD_SEQ_TIMEOUT_EN.
module csd_chain_seq
    import csd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = CSD_TIMEOUT_CYCLES
) (
    input  logic           clk,
    input  logic           rst_n,
    csd_chain_seq_if.slave bus
);

    localparam int unsigned DW = $bits(bus.elem_act);
    localparam int unsigned AW = $bits(bus.vpu_result);
    localparam int unsigned NW = $bits(bus.job_mask);
    localparam int unsigned LW = $bits(bus.job_len);

    seq_state_e        state_q, state_d;
    logic              job_ready_q, job_ready_d;
    logic [DW-1:0]     vpu_act_q, vpu_act_d;
    logic [DW-1:0]     vpu_wgt_q, vpu_wgt_d;
    logic [NW-1:0]     mask_q, mask_d;
    logic              mode_q, mode_d;
    logic [AW-1:0]     res_data_q, res_data_d;
    logic              done_seen_q, done_seen_d;

    logic              job_fire;
    logic              elem_fire;
    logic              cnt_zero;
    logic              cnt_last;
    logic              timeout_hit;

    assign job_fire  = job_ready_q && bus.job_valid;
    assign elem_fire = (state_q == ST_STREAM) && bus.elem_valid;

    csd_seq_elem_cnt #(
        .LEN_WIDTH (LW)
    ) u_elem_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (job_fire),
        .load_val (bus.job_len),
        .dec      (elem_fire),
        .is_zero  (cnt_zero),
        .is_last  (cnt_last)
    );

`ifdef CSD_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          res_err_q, res_err_d;

    // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            res_err_q  <= res_err_d;
        end
    end

    assign bus.res_err = res_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        vpu_act_d   = vpu_act_q;
        vpu_wgt_d   = vpu_wgt_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        res_data_d  = res_data_q;
        done_seen_d = done_seen_q;
`ifdef CSD_SEQ_TIMEOUT_EN
        res_err_d   = res_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (job_fire) begin
                    mask_d      = bus.job_mask;
                    mode_d      = bus.job_mode;
                    done_seen_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                done_seen_d = done_seen_q | bus.vpu_done;
                state_d     = cnt_zero ? ST_WAIT : ST_STREAM;
            end
            ST_STREAM: begin
                done_seen_d = done_seen_q | bus.vpu_done;
                if (elem_fire) begin
                    vpu_act_d = bus.elem_act;
                    vpu_wgt_d = bus.elem_wgt;
                    if (cnt_last) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A completion seen before WAIT counts just like one arriving now.
                if (bus.vpu_done || done_seen_q) begin
                    res_data_d = bus.vpu_result;
`ifdef CSD_SEQ_TIMEOUT_EN
                    res_err_d  = 1'b0;
`endif
                    state_d    = ST_RESULT;
                end else if (timeout_hit) begin
                    res_data_d = '0;
`ifdef CSD_SEQ_TIMEOUT_EN
                    res_err_d  = 1'b1;
`endif
                    state_d    = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so job_ready is low during and immediately after reset.
        job_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            job_ready_q <= 1'b0;
            vpu_act_q   <= '0;
            vpu_wgt_q   <= '0;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            res_data_q  <= '0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_ready_q <= job_ready_d;
            vpu_act_q   <= vpu_act_d;
            vpu_wgt_q   <= vpu_wgt_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            res_data_q  <= res_data_d;
            done_seen_q <= done_seen_d;
        end
    end

    assign bus.job_ready        = job_ready_q;
    assign bus.elem_ready       = (state_q == ST_STREAM);
    assign bus.vpu_start        = (state_q == ST_LOAD);
    assign bus.res_valid        = (state_q == ST_RESULT);
    assign bus.busy             = state_is_busy(state_q);
    assign bus.vpu_act          = vpu_act_q;
    assign bus.vpu_wgt          = vpu_wgt_q;
    assign bus.vpu_sparse_index = mask_q;
    assign bus.vpu_mode         = mode_q;
    assign bus.res_data         = res_data_q;

endmodule

// File: tb/tb_csd_chain_seq.sv
// Randomized self-checking bench for csd_chain_seq; timeout scenario runs when CSD_SEQ_TIMEOUT_EN is defined.
module tb_csd_chain_seq;

    localparam int NDG = 4;
    localparam int DW  = 8;
    localparam int AW  = 48;
    localparam int LW  = 16;
    localparam int TO  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    csd_chain_seq_if #(
        .NUM_DGS     (NDG),
        .DATA_WIDTH  (DW),
        .ACCUM_WIDTH (AW),
        .LEN_WIDTH   (LW)
    ) bus ();

    csd_chain_seq #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int ready_cnt = 0;
    logic [NDG-1:0] exp_mask = '0;
    logic           exp_mode = 1'b0;
    logic [DW-1:0]  act_tab[$];
    logic [DW-1:0]  wgt_tab[$];

    // Advance to just after the next rising edge and tally the pulses seen there.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.vpu_start === 1'b1) start_cnt++;
        if (bus.elem_ready === 1'b1) ready_cnt++;
    endtask

    task automatic drive_idle();
        bus.job_valid  = 1'b0;
        bus.job_len    = '0;
        bus.job_mask   = '0;
        bus.job_mode   = 1'b0;
        bus.elem_valid = 1'b0;
        bus.elem_act   = '0;
        bus.elem_wgt   = '0;
        bus.vpu_done   = 1'b0;
        bus.vpu_result = '0;
        bus.res_ready  = 1'b0;
    endtask

    // dmode: 0 done after WAIT entry, 1 early done mid-stream, 2 done held from before accept,
    // 3 done together with the last element.
    task automatic run_job(input string name, input int len, input logic [NDG-1:0] mask,
                           input logic mode, input int dmode_in, input int hold, input bit gaps);
        logic [AW-1:0] rval;
        logic [DW-1:0] a, w, last_a, last_w;
        int acc, budget, s0, r0, dmode;
        bit fired;
        rval  = {16'($urandom), $urandom};
        dmode = dmode_in;
        if (len == 0 && dmode == 3) dmode = 2;
        s0 = start_cnt;
        r0 = ready_cnt;

        budget = 0;
        while (bus.job_ready !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        total++;
        if (bus.job_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s/job_ready_wait: job_ready=%b expected 1", name, bus.job_ready);
        end

        if (dmode == 2) begin
            bus.vpu_done   = 1'b1;
            bus.vpu_result = rval;
        end
        bus.job_valid = 1'b1;
        bus.job_len   = LW'(len);
        bus.job_mask  = mask;
        bus.job_mode  = mode;
        exp_mask = mask;
        exp_mode = mode;
        tick();
        bus.job_valid = 1'b0;
        bus.job_len   = 16'($urandom);
        bus.job_mask  = 4'($urandom);
        bus.job_mode  = 1'($urandom);

        total++;
        if (bus.vpu_start !== 1'b1 || bus.job_ready !== 1'b0 || bus.elem_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s/start_pulse: start=%b job_ready=%b elem_ready=%b expected 1/0/0",
                     name, bus.vpu_start, bus.job_ready, bus.elem_ready);
        end
        total++;
        if (bus.vpu_sparse_index !== exp_mask || bus.vpu_mode !== exp_mode) begin
            bad++;
            $display("[TB] FAIL %s/cfg_load: mask=%b mode=%b expected %b/%b",
                     name, bus.vpu_sparse_index, bus.vpu_mode, exp_mask, exp_mode);
        end

        if (len == 0) begin
            if (dmode == 1) begin
                bus.vpu_done   = 1'b1;
                bus.vpu_result = rval;
            end
            tick();
            if (dmode == 1) bus.vpu_done = 1'b0;
        end else begin
            tick();
            total++;
            if (bus.elem_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL %s/first_elem_ready: elem_ready=%b expected 1", name, bus.elem_ready);
            end
            acc    = 0;
            budget = 0;
            fired  = 1'b0;
            last_a = bus.vpu_act;
            last_w = bus.vpu_wgt;
            while (acc < len && budget < 400) begin
                budget++;
                bus.elem_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                a = (acc < act_tab.size()) ? act_tab[acc] : 8'($urandom);
                w = (acc < wgt_tab.size()) ? wgt_tab[acc] : 8'($urandom);
                bus.elem_act = a;
                bus.elem_wgt = w;
                if (!fired && bus.elem_valid &&
                    ((dmode == 1 && acc == len / 2) || (dmode == 3 && acc == len - 1))) begin
                    bus.vpu_done   = 1'b1;
                    bus.vpu_result = rval;
                    fired = 1'b1;
                end
                total++;
                if (bus.elem_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL %s/stream_ready: elem_ready=%b expected 1 at element %0d",
                             name, bus.elem_ready, acc);
                end
                tick();
                if (dmode == 1 || dmode == 3) bus.vpu_done = 1'b0;
                if (bus.elem_valid) begin
                    acc++;
                    last_a = a;
                    last_w = w;
                end
                total++;
                if (bus.vpu_act !== last_a || bus.vpu_wgt !== last_w) begin
                    bad++;
                    $display("[TB] FAIL %s/elem_pair: act=%0d wgt=%0d expected %0d/%0d",
                             name, bus.vpu_act, bus.vpu_wgt, last_a, last_w);
                end
            end
            bus.elem_valid = 1'b0;
            total++;
            if (acc != len) begin
                bad++;
                $display("[TB] FAIL %s/stream_budget: accepted=%0d expected %0d", name, acc, len);
            end
        end

        total++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1 || bus.elem_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s/wait_entry: res_valid=%b busy=%b elem_ready=%b expected 0/1/0",
                     name, bus.res_valid, bus.busy, bus.elem_ready);
        end
        if (dmode == 0) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                total++;
                if (bus.res_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL %s/wait_hold: res_valid=%b expected 0", name, bus.res_valid);
                end
            end
            bus.vpu_done   = 1'b1;
            bus.vpu_result = rval;
            tick();
            bus.vpu_done = 1'b0;
        end else begin
            tick();
        end
        total++;
        if (bus.res_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s/result_latency: res_valid=%b expected 1", name, bus.res_valid);
            budget = 0;
            while (bus.res_valid !== 1'b1 && budget < 50) begin
                tick();
                budget++;
            end
        end
        bus.vpu_done   = 1'b0;
        bus.vpu_result = {16'($urandom), $urandom};

        total++;
        if (bus.res_data !== rval || bus.res_err !== 1'b0 || bus.job_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s/result_data: data=%h err=%b job_ready=%b expected %h/0/0",
                     name, bus.res_data, bus.res_err, bus.job_ready, rval);
        end
        repeat (hold) begin
            tick();
            bus.vpu_result = {16'($urandom), $urandom};
            total++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== rval || bus.job_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s/result_hold: valid=%b data=%h job_ready=%b expected 1/%h/0",
                         name, bus.res_valid, bus.res_data, bus.job_ready, rval);
            end
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        total++;
        if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s/result_release: valid=%b job_ready=%b busy=%b expected 0/1/0",
                     name, bus.res_valid, bus.job_ready, bus.busy);
        end
        total++;
        if (bus.vpu_sparse_index !== exp_mask || bus.vpu_mode !== exp_mode) begin
            bad++;
            $display("[TB] FAIL %s/cfg_hold: mask=%b mode=%b expected %b/%b",
                     name, bus.vpu_sparse_index, bus.vpu_mode, exp_mask, exp_mode);
        end
        total++;
        if (start_cnt - s0 != 1) begin
            bad++;
            $display("[TB] FAIL %s/start_count: pulses=%0d expected 1", name, start_cnt - s0);
        end
        if (len == 0) begin
            total++;
            if (ready_cnt != r0) begin
                bad++;
                $display("[TB] FAIL %s/no_elem_ready: cycles=%0d expected 0", name, ready_cnt - r0);
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #3;
        total++;
        if (bus.job_ready !== 1'b0 || bus.elem_ready !== 1'b0 || bus.vpu_start !== 1'b0 ||
            bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.vpu_act !== '0 ||
            bus.vpu_wgt !== '0 || bus.vpu_sparse_index !== '0 || bus.vpu_mode !== 1'b0 ||
            bus.res_data !== '0 || bus.res_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_values: job_ready=%b busy=%b res_valid=%b act=%h data=%h expected all 0",
                     bus.job_ready, bus.busy, bus.res_valid, bus.vpu_act, bus.res_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: job_ready=%b busy=%b expected 1/0", bus.job_ready, bus.busy);
        end
    endtask

    task automatic test_dense();
        act_tab = '{8'd1, 8'd3, 8'd5, 8'd7};
        wgt_tab = '{8'd2, 8'd4, 8'd6, 8'd8};
        run_job("dense", 4, 4'b0000, 1'b0, 0, 0, 1'b0);
        act_tab.delete();
        wgt_tab.delete();
    endtask

    task automatic test_sparse();
        run_job("sparse", 3, 4'b0101, 1'b1, 0, 2, 1'b1);
        bus.job_mask = 4'b1010;
        repeat (3) tick();
        total++;
        if (bus.vpu_sparse_index !== 4'b0101 || bus.vpu_mode !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sparse/idle_hold: mask=%b mode=%b expected 0101/1",
                     bus.vpu_sparse_index, bus.vpu_mode);
        end
        run_job("sparse_next", 2, 4'b0000, 1'b0, 3, 0, 1'b0);
    endtask

    task automatic test_len_zero();
        run_job("len0", 0, 4'b0011, 1'b0, 2, 0, 1'b0);
        run_job("len0_early", 0, 4'b1000, 1'b1, 1, 1, 1'b0);
    endtask

    task automatic test_early_done();
        run_job("early_done", 4, 4'b0000, 1'b0, 1, 5, 1'b1);
        run_job("done_with_last", 3, 4'b0110, 1'b0, 3, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            run_job("back_to_back", 1 + i, 4'(i), 1'(i), 3, 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_stream();
        int budget;
        budget = 0;
        while (bus.job_ready !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        bus.job_valid = 1'b1;
        bus.job_len   = 16'd5;
        bus.job_mask  = 4'b1111;
        bus.job_mode  = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        tick();
        bus.elem_valid = 1'b1;
        bus.elem_act   = 8'h11;
        bus.elem_wgt   = 8'h22;
        tick();
        bus.elem_act   = 8'h33;
        bus.elem_wgt   = 8'h44;
        tick();
        total++;
        if (bus.vpu_act !== 8'h33 || bus.elem_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_mid/pre_reset: act=%h elem_ready=%b expected 33/1",
                     bus.vpu_act, bus.elem_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.job_ready !== 1'b0 || bus.elem_ready !== 1'b0 || bus.vpu_start !== 1'b0 ||
            bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.vpu_act !== '0 ||
            bus.vpu_wgt !== '0 || bus.vpu_sparse_index !== '0 || bus.vpu_mode !== 1'b0 ||
            bus.res_data !== '0 || bus.res_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid/async_clear: elem_ready=%b busy=%b act=%h mask=%b expected all 0",
                     bus.elem_ready, bus.busy, bus.vpu_act, bus.vpu_sparse_index);
        end
        drive_idle();
        exp_mask = '0;
        exp_mode = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rst_mid/no_result: res_valid=%b busy=%b expected 0/0",
                         bus.res_valid, bus.busy);
            end
        end
        run_job("after_reset", 3, 4'b0010, 1'b0, 0, 1, 1'b1);
    endtask

    task automatic test_random_jobs();
        for (int i = 0; i < 24; i++) begin
            run_job("random", $urandom_range(0, 6), 4'($urandom), 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end
    endtask

`ifdef CSD_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int budget;
        bit early;
        budget = 0;
        while (bus.job_ready !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        bus.job_valid = 1'b1;
        bus.job_len   = 16'd1;
        bus.job_mask  = 4'b0001;
        bus.job_mode  = 1'b0;
        exp_mask = 4'b0001;
        exp_mode = 1'b0;
        tick();
        bus.job_valid = 1'b0;
        tick();
        bus.elem_valid = 1'b1;
        bus.elem_act   = 8'h5a;
        bus.elem_wgt   = 8'ha5;
        bus.vpu_result = 48'hdead_beef_cafe;
        tick();
        bus.elem_valid = 1'b0;
        early = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin
            bad++;
            $display("[TB] FAIL timeout/early: res_valid rose before %0d cycles in WAIT", TO);
        end
        tick();
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 || bus.res_data !== '0) begin
            bad++;
            $display("[TB] FAIL timeout/abort: valid=%b err=%b data=%h expected 1/1/0",
                     bus.res_valid, bus.res_err, bus.res_data);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        total++;
        if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout/release: valid=%b job_ready=%b expected 0/1",
                     bus.res_valid, bus.job_ready);
        end
    endtask
`endif

    initial begin
        $display("[TB] csd_chain_seq bench starting");
        test_reset();
        test_dense();
        test_sparse();
        test_len_zero();
        test_early_done();
        test_back_to_back();
        test_reset_mid_stream();
        test_random_jobs();
`ifdef CSD_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] bench did not finish");
    end

endmodule
